// File: rtl/wb_pkg.sv
// Shared constants, latch layout and overflow classification for the writeback stage.
// Used by stage_writeback and wb_decode.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] RSTATUS = 5'd30;
  localparam logic [REG_AW-1:0] RLINK   = 5'd31;

  typedef enum logic [4:0] {
    OP_ALU  = 5'b00000,
    OP_J    = 5'b00001,
    OP_BNE  = 5'b00010,
    OP_JAL  = 5'b00011,
    OP_JR   = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_BLT  = 5'b00110,
    OP_SW   = 5'b00111,
    OP_LW   = 5'b01000,
    OP_SETX = 5'b10101,
    OP_BEX  = 5'b10110
  } opcode_e;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam logic [DATA_W-1:0] OVF_CODE_ADD  = 32'd1;
  localparam logic [DATA_W-1:0] OVF_CODE_ADDI = 32'd2;
  localparam logic [DATA_W-1:0] OVF_CODE_SUB  = 32'd3;

  typedef struct packed {
    logic [31:0]       insn;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pc_plus1;
    logic              overflow;
  } wb_latch_t;

  // True when this instruction/flag pair writes an overflow code instead of its result.
  function automatic logic is_ovf_wb(input logic [31:0] insn, input logic overflow);
    return overflow &&
           ((insn[31:27] == OP_ADDI) ||
            ((insn[31:27] == OP_ALU) && ((insn[6:2] == ALU_ADD) || (insn[6:2] == ALU_SUB))));
  endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational writeback decode: latched MEM/WB fields -> regfile write enable, destination, data.
module wb_decode
  import wb_pkg::*;
(
  input  wb_latch_t          latch_i,
  output logic               we_o,
  output logic [REG_AW-1:0]  dest_o,
  output logic [DATA_W-1:0]  data_o
);

  logic       writer;
  logic [4:0] alu_op;

  assign alu_op = latch_i.insn[6:2];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    writer = 1'b0;
    dest_o = latch_i.insn[26:22];
    data_o = latch_i.alu_result;
    case (latch_i.insn[31:27])
      OP_ALU: begin
        writer = 1'b1;
        if (latch_i.overflow && alu_op == ALU_ADD) begin
          dest_o = RSTATUS;
          data_o = OVF_CODE_ADD;
        end else if (latch_i.overflow && alu_op == ALU_SUB) begin
          dest_o = RSTATUS;
          data_o = OVF_CODE_SUB;
        end
      end
      OP_ADDI: begin
        writer = 1'b1;
        if (latch_i.overflow) begin
          dest_o = RSTATUS;
          data_o = OVF_CODE_ADDI;
        end
      end
      OP_LW: begin
        writer = 1'b1;
        data_o = latch_i.mem_data;
      end
      OP_JAL: begin
        writer = 1'b1;
        dest_o = RLINK;
        data_o = latch_i.pc_plus1;
      end
      OP_SETX: begin
        writer = 1'b1;
        dest_o = RSTATUS;
        data_o = DATA_W'(latch_i.insn[26:0]);
      end
      default: writer = 1'b0;
    endcase
    // r0 is hardwired, so a write aimed at it is suppressed while dest/data stay visible.
    we_o = writer && (dest_o != '0);
  end

endmodule

// File: rtl/stage_writeback.sv
// MEM/WB pipeline latch plus writeback decode driving the regfile write port.
// Optional WB_EXC_COUNT_EN adds a saturating count of overflow writebacks on exc_count.
module stage_writeback
  import wb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               wb_enable,
  input  logic               wb_flush,
  input  logic [31:0]        m_insn,
  input  logic [DATA_W-1:0]  m_alu_result,
  input  logic [DATA_W-1:0]  m_mem_data,
  input  logic [DATA_W-1:0]  m_pc_plus1,
  input  logic               m_overflow,
  output logic [31:0]        w_insn,
  output logic               ctrl_writeEnable,
  output logic [REG_AW-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0]  data_writeReg
`ifdef WB_EXC_COUNT_EN
  ,
  output logic [7:0]         exc_count
`endif
);

  wb_latch_t latch_q, latch_d;

  // Flush wins over enable; an all-zero latch decodes as add r0,r0,r0 (nop).
  always_comb begin
    latch_d = latch_q;
    if (wb_flush) begin
      latch_d = '0;
    end else if (wb_enable) begin
      latch_d = '{insn:       m_insn,
                  alu_result: m_alu_result,
                  mem_data:   m_mem_data,
                  pc_plus1:   m_pc_plus1,
                  overflow:   m_overflow};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) latch_q <= '0;
    else       latch_q <= latch_d;
  end

  assign w_insn = latch_q.insn;

  wb_decode u_decode (
    .latch_i (latch_q),
    .we_o    (ctrl_writeEnable),
    .dest_o  (ctrl_writeReg),
    .data_o  (data_writeReg)
  );

`ifdef WB_EXC_COUNT_EN
  logic [7:0] exc_q, exc_d;

  always_comb begin
    exc_d = exc_q;
    if (!wb_flush && wb_enable && is_ovf_wb(m_insn, m_overflow) && exc_q != 8'hFF)
      exc_d = exc_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) exc_q <= '0;
    else       exc_q <= exc_d;
  end

  assign exc_count = exc_q;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback: directed scenarios plus random traffic against a reference model.
module tb_stage_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_enable, wb_flush;
  logic [31:0] m_insn, m_alu_result, m_mem_data, m_pc_plus1;
  logic        m_overflow;
  logic [31:0] w_insn;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`ifdef WB_EXC_COUNT_EN
  logic [7:0]  exc_count;
`endif

  stage_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .wb_enable        (wb_enable),
    .wb_flush         (wb_flush),
    .m_insn           (m_insn),
    .m_alu_result     (m_alu_result),
    .m_mem_data       (m_mem_data),
    .m_pc_plus1       (m_pc_plus1),
    .m_overflow       (m_overflow),
    .w_insn           (w_insn),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
`ifdef WB_EXC_COUNT_EN
    ,
    .exc_count        (exc_count)
`endif
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  // Reference view of what the stage should be holding.
  logic [31:0] l_insn, l_alu, l_mem, l_pc;
  logic        l_ovf;
  int          l_exc;

  function automatic logic [31:0] mk(input int op, input int rd, input logic [21:0] low);
    logic [31:0] r;
    r = (32'(op) << 27) | (32'(rd) << 22) | 32'(low);
    return r;
  endfunction

  function automatic logic [31:0] mk_alu(input int rd, input int alu_op);
    return mk(0, rd, 22'(alu_op << 2) | 22'h2A000);
  endfunction

  // Writeback rules written out from the instruction semantics.
  function automatic void model(input logic [31:0] insn, alu, mem, pc, input logic ovf,
                                output bit writer, output bit we,
                                output int dest, output logic [31:0] data);
    int op, rd, aop;
    op  = int'(insn >> 27);
    rd  = int'((insn >> 22) % 32);
    aop = int'((insn >> 2) % 32);
    writer = (op == 0) || (op == 5) || (op == 8) || (op == 3) || (op == 21);
    dest = rd;
    data = alu;
    if      (op == 0 && ovf && aop == 0) begin dest = 30; data = 1; end
    else if (op == 0 && ovf && aop == 1) begin dest = 30; data = 3; end
    else if (op == 5 && ovf)             begin dest = 30; data = 2; end
    else if (op == 8)                    data = mem;
    else if (op == 3)                    begin dest = 31; data = pc; end
    else if (op == 21)                   begin dest = 30; data = insn % 32'h0800_0000; end
    we = writer && dest != 0;
  endfunction

  function automatic bit model_ovf_wb(input logic [31:0] insn, input logic ovf);
    int op, aop;
    op  = int'(insn >> 27);
    aop = int'((insn >> 2) % 32);
    return ovf && ((op == 5) || (op == 0 && (aop == 0 || aop == 1)));
  endfunction

  task automatic clear_model();
    l_insn = 0; l_alu = 0; l_mem = 0; l_pc = 0; l_ovf = 0; l_exc = 0;
  endtask

  // One clock of stimulus; returns #1 after the rising edge with the model updated.
  task automatic drive(input logic [31:0] insn, alu, mem, pc, input logic ovf, input logic en, fl);
    @(negedge clock);
    m_insn = insn; m_alu_result = alu; m_mem_data = mem; m_pc_plus1 = pc; m_overflow = ovf;
    wb_enable = en; wb_flush = fl;
    @(posedge clock);
    if (fl) begin
      l_insn = 0; l_alu = 0; l_mem = 0; l_pc = 0; l_ovf = 0;
    end else if (en) begin
      if (model_ovf_wb(insn, ovf) && l_exc < 255) l_exc++;
      l_insn = insn; l_alu = alu; l_mem = mem; l_pc = pc; l_ovf = ovf;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    #2;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_enable = 0; wb_flush = 0;
    m_insn = 0; m_alu_result = 0; m_mem_data = 0; m_pc_plus1 = 0; m_overflow = 0;
    clear_model();
    #2;
    n_total++; if (w_insn !== 32'h0) $display("FAIL reset_insn: got %h expected 0", w_insn); else n_pass++;
    n_total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL reset_we: got %b expected 0", ctrl_writeEnable); else n_pass++;
    n_total++; if (ctrl_writeReg !== 5'd0) $display("FAIL reset_reg: got %0d expected 0", ctrl_writeReg); else n_pass++;
    n_total++; if (data_writeReg !== 32'h0) $display("FAIL reset_data: got %h expected 0", data_writeReg); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(mk(5, 9, 22'h55), 32'h1234, 32'h5678, 32'h9, 1'b0, 1'b0, 1'b0);
      n_total++;
      if ({w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 70'h0)
        $display("FAIL idle_after_reset: got insn=%h we=%b reg=%0d data=%h expected all 0",
                 w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      else n_pass++;
    end
  endtask

  task automatic test_addi_lw();
    drive(32'h2940_0007, 32'd7, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'd7})
      $display("FAIL addi: got we=%b reg=%0d data=%h expected we=1 reg=5 data=7",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    n_total++; if (w_insn !== 32'h2940_0007) $display("FAIL addi_insn: got %h expected 29400007", w_insn); else n_pass++;
    drive(mk(8, 3, 22'h0), 32'h10, 32'hDEAD_BEEF, $urandom, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'hDEAD_BEEF})
      $display("FAIL lw: got we=%b reg=%0d data=%h expected we=1 reg=3 data=deadbeef",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] insns [5];
    logic [4:0]  regs  [5];
    logic [31:0] datas [5];
    insns = '{mk_alu(4, 0), mk_alu(4, 1), mk(5, 4, 22'h3), mk_alu(4, 2), mk(8, 6, 22'h0)};
    regs  = '{5'd30, 5'd30, 5'd30, 5'd4, 5'd6};
    datas = '{32'd1, 32'd3, 32'd2, 32'hA5A5_0001, 32'h0BAD_F00D};
    for (int i = 0; i < 5; i++) begin
      drive(insns[i], 32'hA5A5_0001, 32'h0BAD_F00D, 32'h44, 1'b1, 1'b1, 1'b0);
      n_total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, regs[i], datas[i]})
        $display("FAIL overflow_%0d: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h",
                 i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, regs[i], datas[i]);
      else n_pass++;
    end
  endtask

  task automatic test_jal_setx_nonwriters();
    drive(mk(3, 7, 22'h100), 32'h77, 32'h88, 32'h21, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd31, 32'h21})
      $display("FAIL jal: got we=%b reg=%0d data=%h expected we=1 reg=31 data=21",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    drive(mk(21, 0, 22'h123), 32'h77, 32'h88, 32'h21, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd30, 32'h123})
      $display("FAIL setx: got we=%b reg=%0d data=%h expected we=1 reg=30 data=123",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    drive(mk(7, 12, 22'h4), 32'h77, 32'h88, 32'h21, 1'b0, 1'b1, 1'b0);
    n_total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL sw_we: got %b expected 0", ctrl_writeEnable); else n_pass++;
    drive(mk(2, 12, 22'h4), 32'h77, 32'h88, 32'h21, 1'b1, 1'b1, 1'b0);
    n_total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL bne_we: got %b expected 0", ctrl_writeEnable); else n_pass++;
  endtask

  task automatic test_r0_flush_hold();
    drive(mk_alu(0, 0), 32'h99, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd0, 32'h99})
      $display("FAIL alu_r0: got we=%b reg=%0d data=%h expected we=0 reg=0 data=99",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    drive(32'h2940_0007, 32'd7, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(mk(8, 3, 22'h0), 32'h10, 32'hCAFE, 32'h5, 1'b0, 1'b1, 1'b1);
    n_total++;
    if ({w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 70'h0)
      $display("FAIL flush: got insn=%h we=%b reg=%0d data=%h expected all 0",
               w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    drive(mk(5, 7, 22'h9), 32'd9, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      n_total++;
      if ({w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {mk(5, 7, 22'h9), 1'b1, 5'd7, 32'd9})
        $display("FAIL hold_%0d: got insn=%h we=%b reg=%0d data=%h expected insn=%h we=1 reg=7 data=9",
                 i, w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg, mk(5, 7, 22'h9));
      else n_pass++;
    end
    // Assert reset between edges: the latch must clear without waiting for a clock.
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    n_total++;
    if ({w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 70'h0)
      $display("FAIL async_reset: got insn=%h we=%b reg=%0d data=%h expected all 0",
               w_insn, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int ops [11] = '{0, 5, 8, 3, 21, 7, 1, 2, 4, 6, 22};
    bit writer, we;
    int dest, errs;
    logic [31:0] data, insn;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      insn = mk(ops[$urandom_range(10)], ($urandom_range(7) == 0) ? 0 : $urandom_range(31), 22'($urandom));
      if (insn[31:27] == 5'd0) insn[6:2] = 5'($urandom_range(3));
      drive(insn, $urandom, $urandom, $urandom, 1'($urandom_range(1)),
            ($urandom_range(3) != 0), ($urandom_range(9) == 0));
      model(l_insn, l_alu, l_mem, l_pc, l_ovf, writer, we, dest, data);
      n_total++;
      if (w_insn !== l_insn || ctrl_writeEnable !== we) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_we_%0d: got insn=%h we=%b expected insn=%h we=%b", i, w_insn, ctrl_writeEnable, l_insn, we);
      end else n_pass++;
      if (writer) begin
        n_total++;
        if (ctrl_writeReg !== 5'(dest) || data_writeReg !== data) begin
          errs++;
          if (errs < 10)
            $display("FAIL rand_wb_%0d: got reg=%0d data=%h expected reg=%0d data=%h",
                     i, ctrl_writeReg, data_writeReg, dest, data);
        end else n_pass++;
      end
    end
  endtask

`ifdef WB_EXC_COUNT_EN
  task automatic test_exc_count();
    pulse_reset();
    n_total++; if (exc_count !== 8'd0) $display("FAIL exc_reset: got %0d expected 0", exc_count); else n_pass++;
    for (int i = 0; i < 5; i++) drive(mk_alu(4, 1), 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_total++; if (exc_count !== 8'd5) $display("FAIL exc_five: got %0d expected 5", exc_count); else n_pass++;
    for (int i = 0; i < 3; i++) drive(mk(5, 2, 22'h1), 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(mk(5, 2, 22'h1), 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(mk_alu(4, 0), 32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(mk_alu(4, 2), 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_total++; if (exc_count !== 8'd5) $display("FAIL exc_nocount: got %0d expected 5", exc_count); else n_pass++;
    for (int i = 0; i < 300; i++) drive(mk_alu(9, 0), 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_total++; if (exc_count !== 8'd255) $display("FAIL exc_saturate: got %0d expected 255", exc_count); else n_pass++;
    n_total++; if (int'(exc_count) !== l_exc) $display("FAIL exc_model: got %0d expected %0d", exc_count, l_exc); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_addi_lw();
    test_overflow();
    test_jal_setx_nonwriters();
    test_r0_flush_hold();
    test_random();
`ifdef WB_EXC_COUNT_EN
    test_exc_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
